load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Request/response front end for the byte-addressed data memory: accepts one load/store from EX,
//  checks alignment/range/funct3, drives the memory's read/write/addr/funct3 controls for exactly
//  one cycle, captures the result and holds it for WB. Sits directly upstream of the data memory.
// PARAMETERS
//  MEM_BYTES  4096  data memory size in bytes; addr >= MEM_BYTES is out of range
//  RD_W       5     destination register index width
// PORTS
//  clk           in   1      single clock, all state on posedge
//  rst_n         in   1      asynchronous active-low reset
//  req_valid     in   1      EX presents a request
//  req_ready     out  1      LSU can accept (high only in IDLE)
//  req_is_store  in   1      1 = store, 0 = load
//  req_funct3    in   3      RV32I load/store funct3
//  req_addr      in   32     byte address (rs1 + imm)
//  req_wdata     in   32     store data (rs2)
//  req_rd        in   RD_W   load destination
//  mem_read      out  1      to memory
//  mem_write     out  1      to memory
//  mem_addr      out  32     to memory
//  mem_wdata     out  32     to memory
//  mem_funct3    out  3      to memory
//  mem_rdata     in   32     from memory, combinational, already sign/zero extended
//  rsp_valid     out  1      result held for WB
//  rsp_ready     in   1      WB consumes
//  rsp_is_load   out  1      result is a load (WB writes rsp_rd)
//  rsp_data      out  32     load data; 0 for stores and faults
//  rsp_rd        out  RD_W   echoed req_rd
//  rsp_fault     out  2      00 none, 01 misaligned, 10 out of range, 11 illegal funct3
//  rsp_fault_addr out 32     offending req_addr when fault != 00, else 0
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; req_ready=1; all mem_* and rsp_* outputs 0.
//  - States IDLE -> ACCESS -> RESP -> IDLE; faulting request goes IDLE -> RESP directly.
//  - IDLE: req_ready=1. Handshake req_valid&req_ready at edge N latches all req_* fields.
//  - Checks (combinational on request, priority illegal > misaligned > range):
//    illegal: store funct3 not in {000,001,010}; load funct3 not in {000,001,010,100,101}.
//    misaligned: halfword (x01) with addr[0]=1; word (010) with addr[1:0]!=00.
//    range: addr + size - 1 >= MEM_BYTES (size 1/2/4 from funct3[1:0]); 33-bit compare, no wrap.
//  - ACCESS (cycle N+1 only): mem_read=~is_store, mem_write=is_store, mem_addr/wdata/funct3 =
//    latched values; exactly one cycle, store commits at end of this cycle. Loads capture
//    mem_rdata into rsp_data at that edge. mem_* are 0 in every other state (decoded from state).
//  - RESP: rsp_valid=1 from N+2 (no fault) or N+1 (fault); all rsp_* stable until rsp_valid&rsp_ready,
//    then IDLE. Faulted request never asserts mem_read/mem_write.
//  - Throughput: max one request per 3 cycles (2 for faults); back-pressure via rsp_ready only.
//  - rsp_valid&rsp_ready and new req_valid same cycle: request not accepted that cycle (req_ready=0
//    in RESP); accepted next cycle in IDLE.
//  - Reset mid-ACCESS: mem_write drops immediately; store written only if edge preceded reset.
//  - req_* changes while req_ready=0 ignored.
// STRUCTURE
//  - Package lsu_pkg: funct3 constants (F3_B/H/W/BU/HU), state enum (IDLE/ACCESS/RESP),
//    fault codes (FLT_NONE/MISAL/RANGE/ILLEGAL).
//  - Sub-module lsu_check: combinational funct3/alignment/range check -> 2-bit fault code.
//  - Top: FSM, request latch, response register.
// TESTING
//  - SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_write 1 cycle at N+1; LW rsp_data
//    0xDEADBEEF at N+2, fault 00.
//  - SB 0x21 data 0x80, LB 0x21 -> 0xFFFFFF80; LBU 0x21 -> 0x00000080; store rsp_is_load=0.
//  - LW 0x12 -> rsp_fault 01, fault_addr 0x12, rsp_valid at N+1, mem_read never high.
//  - LW 0xFFC ok; LW 0x1000 -> fault 10; SH 0xFFF -> fault 01 (misaligned wins over range);
//    LW 0xFFFFFFFC -> fault 10 (no wrap).
//  - Load funct3 011 and store funct3 100 -> fault 11; rsp_ready held 0 for 5 cycles -> all rsp_*
//    stable, req_ready=0.
//  - rst_n low during ACCESS of SW -> mem_write 0 immediately, all outputs reset, memory unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: funct3 encodings, FSM state,
// fault codes and the registered memory-request payload.
package lsu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned F3_W_BITS = 3;

    localparam logic [F3_W_BITS-1:0] F3_B  = 3'b000;
    localparam logic [F3_W_BITS-1:0] F3_H  = 3'b001;
    localparam logic [F3_W_BITS-1:0] F3_W  = 3'b010;
    localparam logic [F3_W_BITS-1:0] F3_BU = 3'b100;
    localparam logic [F3_W_BITS-1:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } lsu_state_e;

    typedef enum logic [1:0] {
        FLT_NONE    = 2'b00,
        FLT_MISAL   = 2'b01,
        FLT_RANGE   = 2'b10,
        FLT_ILLEGAL = 2'b11
    } lsu_fault_e;

    typedef struct packed {
        logic                 read;
        logic                 write;
        logic [XLEN-1:0]      addr;
        logic [XLEN-1:0]      wdata;
        logic [F3_W_BITS-1:0] funct3;
    } lsu_mem_req_t;

    // Access size in bytes from funct3[1:0]; 2'b11 is never legal so its value is irrelevant.
    function automatic logic [2:0] access_size(input logic [1:0] sz);
        case (sz)
            2'b00:   access_size = 3'd1;
            2'b01:   access_size = 3'd2;
            default: access_size = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_check.sv
// Combinational request checker: illegal funct3 beats misalignment, which beats range.
module lsu_check
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic                 i_is_store,
    input  logic [F3_W_BITS-1:0] i_funct3,
    input  logic [XLEN-1:0]      i_addr,
    output lsu_fault_e           o_fault_c
);

    logic        w_illegal;
    logic        w_misal;
    logic        w_range;
    logic [XLEN:0] w_last;

    always_comb begin
        if (i_is_store) begin
            w_illegal = i_funct3[2] | (i_funct3[1:0] == 2'b11);
        end else begin
            w_illegal = (i_funct3[1:0] == 2'b11) | (i_funct3[2] & i_funct3[1]);
        end
    end

    assign w_misal = ((i_funct3[1:0] == 2'b01) & i_addr[0]) |
                     ((i_funct3[1:0] == 2'b10) & (i_addr[1:0] != 2'b00));

    // 33-bit last-byte address so accesses near 2^32 cannot wrap back into range.
    assign w_last  = {1'b0, i_addr} + (XLEN+1)'(access_size(i_funct3[1:0])) - (XLEN+1)'(1);
    assign w_range = (w_last >= (XLEN+1)'(MEM_BYTES));

    always_comb begin
        o_fault_c = FLT_NONE;
        if (w_illegal) begin
            o_fault_c = FLT_ILLEGAL;
        end else if (w_misal) begin
            o_fault_c = FLT_MISAL;
        end else if (w_range) begin
            o_fault_c = FLT_RANGE;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store front end: accepts one request, drives the data memory for a single cycle,
// and holds the response (or fault) until writeback consumes it.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 4096,
    parameter int unsigned RD_W      = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_is_store,
    input  logic [F3_W_BITS-1:0] req_funct3,
    input  logic [XLEN-1:0]      req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    input  logic [RD_W-1:0]      req_rd,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [XLEN-1:0]      mem_addr,
    output logic [XLEN-1:0]      mem_wdata,
    output logic [F3_W_BITS-1:0] mem_funct3,
    input  logic [XLEN-1:0]      mem_rdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_is_load,
    output logic [XLEN-1:0]      rsp_data,
    output logic [RD_W-1:0]      rsp_rd,
    output logic [1:0]           rsp_fault,
    output logic [XLEN-1:0]      rsp_fault_addr
);

    lsu_state_e   r_state;
    lsu_mem_req_t r_mem;
    lsu_fault_e   w_fault;
    logic         w_accept;

    lsu_check #(
        .MEM_BYTES (MEM_BYTES)
    ) u_check (
        .i_is_store (req_is_store),
        .i_funct3   (req_funct3),
        .i_addr     (req_addr),
        .o_fault_c  (w_fault)
    );

    assign w_accept   = req_valid & req_ready;

    assign mem_read   = r_mem.read;
    assign mem_write  = r_mem.write;
    assign mem_addr   = r_mem.addr;
    assign mem_wdata  = r_mem.wdata;
    assign mem_funct3 = r_mem.funct3;

    // The memory request register is non-zero only while in ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_mem          <= '0;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_is_load    <= 1'b0;
            rsp_data       <= '0;
            rsp_rd         <= '0;
            rsp_fault      <= 2'b00;
            rsp_fault_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        req_ready <= 1'b0;
                        rsp_rd    <= req_rd;
                        rsp_data  <= '0;
                        rsp_fault <= w_fault;
                        if (w_fault != FLT_NONE) begin
                            // A faulted load has no result, so WB must not write rsp_rd.
                            rsp_is_load    <= 1'b0;
                            rsp_fault_addr <= req_addr;
                            rsp_valid      <= 1'b1;
                            r_state        <= RESP;
                        end else begin
                            rsp_is_load    <= ~req_is_store;
                            rsp_fault_addr <= '0;
                            r_mem.read     <= ~req_is_store;
                            r_mem.write    <= req_is_store;
                            r_mem.addr     <= req_addr;
                            r_mem.wdata    <= req_wdata;
                            r_mem.funct3   <= req_funct3;
                            r_state        <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (r_mem.read) begin
                        rsp_data <= mem_rdata;
                    end
                    r_mem     <= '0;
                    rsp_valid <= 1'b1;
                    r_state   <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_mem     <= '0;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule
